// File: rtl/modulo_sequencer.sv
// Control FSM for the repeated-subtraction modulo datapath: sequences operand load,
// compare/subtract micro-steps and reports the quotient through its own iteration counter.
module modulo_sequencer #(
   parameter int          ALU_LAT  = 2,
   parameter logic [15:0] MAX_ITER = 16'hFFFF,
   parameter logic [2:0]  MODE_SUB = 3'd1,
   parameter logic [2:0]  MODE_LT  = 3'd2
) (
   input  logic        clk,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [15:0] Zahl1_i,
   input  logic [15:0] Zahl2_i,
   input  logic        dp_valid_i,
   output logic [2:0]  alu_mode_o,
   output logic        wren_update_Zahlen_o,
   output logic        wren_Zahl1_to_erg_o,
   output logic        wren_res_to_erg_o,
   output logic        wren_term_erg_o,
   output logic        erg_to_alu_a_o,
   output logic        Zahl2_to_alu_b_o,
   output logic        check_for_termination_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        error_o,
   output logic [15:0] iter_o
);

   localparam int WW = $clog2(ALU_LAT + 2);
   localparam logic [WW-1:0] WAIT_LAST = WW'(ALU_LAT);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_INIT, S_CMP, S_CHECK, S_SUB, S_DONE, S_ERR
   } state_t;

   state_t        state_q, state_d;
   logic [WW-1:0] wait_q, wait_d;
   logic [15:0]   iter_q, iter_d;
   logic          wait_last;
   logic          illegal_ops;

   assign wait_last   = (wait_q == WAIT_LAST);
   assign illegal_ops = (Zahl2_i == 16'd0) || Zahl2_i[15] || Zahl1_i[15];
   assign iter_o      = iter_q;
   assign busy_o      = (state_q != S_IDLE);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         wait_q  <= '0;
         iter_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         iter_q  <= iter_d;
      end
   end

   // NOTE: every output and next-state value gets a default first so no latch is inferred.
   always_comb begin
      state_d                 = state_q;
      wait_d                  = '0;
      iter_d                  = iter_q;
      alu_mode_o              = 3'd0;
      wren_update_Zahlen_o    = 1'b0;
      wren_Zahl1_to_erg_o     = 1'b0;
      wren_res_to_erg_o       = 1'b0;
      wren_term_erg_o         = 1'b0;
      erg_to_alu_a_o          = 1'b0;
      Zahl2_to_alu_b_o        = 1'b0;
      check_for_termination_o = 1'b0;
      done_o                  = 1'b0;
      error_o                 = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               if (illegal_ops) begin
                  state_d = S_ERR;
               end else begin
                  state_d = S_LOAD;
                  iter_d  = '0;
               end
            end
         end
         S_LOAD: begin
            wren_update_Zahlen_o = 1'b1;
            state_d              = S_INIT;
         end
         S_INIT: begin
            wren_Zahl1_to_erg_o = 1'b1;
            state_d             = S_CMP;
         end
         S_CMP: begin
            erg_to_alu_a_o   = 1'b1;
            Zahl2_to_alu_b_o = 1'b1;
            alu_mode_o       = MODE_LT;
            if (wait_last) begin
               wren_term_erg_o = 1'b1;
               state_d         = S_CHECK;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_CHECK: begin
            check_for_termination_o = 1'b1;
            if (dp_valid_i)              state_d = S_DONE;
            else if (iter_q == MAX_ITER) state_d = S_ERR;
            else                         state_d = S_SUB;
         end
         S_SUB: begin
            erg_to_alu_a_o   = 1'b1;
            Zahl2_to_alu_b_o = 1'b1;
            alu_mode_o       = MODE_SUB;
            if (wait_last) begin
               wren_res_to_erg_o = 1'b1;
               iter_d            = iter_q + 16'd1;
               state_d           = S_CMP;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_DONE: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
         S_ERR: begin
            done_o  = 1'b1;
            error_o = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_modulo_sequencer.sv
// Directed bench: two sequencers (default and MAX_ITER=4), each driving a small
// behavioural model of the modulo datapath with a two-cycle registered ALU.
module tb_modulo_sequencer;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [1:0]       start;
   logic [1:0][15:0] z1, z2;
   logic [1:0]       dp_valid;
   logic [1:0][2:0]  alu_mode;
   logic [1:0]       w_upd, w_z1, w_res, w_term, sel_a, sel_b, chk, busy, done, err;
   logic [1:0][15:0] iter;

   // datapath model state
   logic [1:0][15:0] zr1, zr2, erg, s1, wbb;
   logic [1:0]       term;

   int n_cmp  = 0;
   int n_fail = 0;

   modulo_sequencer u_dut0 (
      .clk(clk), .rst_i(rst), .start_i(start[0]), .Zahl1_i(z1[0]), .Zahl2_i(z2[0]),
      .dp_valid_i(dp_valid[0]), .alu_mode_o(alu_mode[0]), .wren_update_Zahlen_o(w_upd[0]),
      .wren_Zahl1_to_erg_o(w_z1[0]), .wren_res_to_erg_o(w_res[0]), .wren_term_erg_o(w_term[0]),
      .erg_to_alu_a_o(sel_a[0]), .Zahl2_to_alu_b_o(sel_b[0]), .check_for_termination_o(chk[0]),
      .busy_o(busy[0]), .done_o(done[0]), .error_o(err[0]), .iter_o(iter[0]));

   modulo_sequencer #(.MAX_ITER(16'd4)) u_dut1 (
      .clk(clk), .rst_i(rst), .start_i(start[1]), .Zahl1_i(z1[1]), .Zahl2_i(z2[1]),
      .dp_valid_i(dp_valid[1]), .alu_mode_o(alu_mode[1]), .wren_update_Zahlen_o(w_upd[1]),
      .wren_Zahl1_to_erg_o(w_z1[1]), .wren_res_to_erg_o(w_res[1]), .wren_term_erg_o(w_term[1]),
      .erg_to_alu_a_o(sel_a[1]), .Zahl2_to_alu_b_o(sel_b[1]), .check_for_termination_o(chk[1]),
      .busy_o(busy[1]), .done_o(done[1]), .error_o(err[1]), .iter_o(iter[1]));

   function automatic logic [15:0] alu(input logic [2:0] mode, input logic [15:0] a, input logic [15:0] b);
      case (mode)
         3'd1:    return a - b;
         3'd2:    return {15'd0, ($signed(a) < $signed(b))};
         default: return 16'd0;
      endcase
   endfunction

   assign dp_valid = chk & term;

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         s1[i]  <= alu(alu_mode[i], erg[i], zr2[i]);
         wbb[i] <= s1[i];
         if (w_upd[i]) begin
            zr1[i] <= z1[i];
            zr2[i] <= z2[i];
         end
         if (w_z1[i])   erg[i]  <= zr1[i];
         if (w_res[i])  erg[i]  <= wbb[i];
         if (w_term[i]) term[i] <= wbb[i][0];
      end
   end

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if ({alu_mode[i], w_upd[i], w_z1[i], w_res[i], w_term[i], sel_a[i], sel_b[i], chk[i],
              busy[i], done[i], err[i], iter[i]} !== 29'd0) begin
            n_fail++;
            $display("FAIL reset_outputs dut%0d: got mode=%0d busy=%b done=%b iter=%0d, need all 0",
                     i, alu_mode[i], busy[i], done[i], iter[i]);
         end
      end
      rst = 1'b0;
   endtask

   // Runs one operation; caller is positioned #1 after a clock edge.
   task automatic run_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                         input int exp_cyc, input logic exp_err, input logic [15:0] exp_iter,
                         input logic [15:0] exp_erg, input bit busy_pulse, input string name);
      int cyc = 1, done_cyc = 0;
      int n_upd = 0, n_z1 = 0, n_term = 0, n_chk = 0, n_res = 0;
      int bad_onehot = 0, bad_mode = 0, bad_busy = 0;
      logic got_err = 1'b0;
      logic [15:0] got_iter = 16'd0;
      int e_upd, e_z1, e_term, e_chk, e_res;
      z1[idx] = a; z2[idx] = b; start[idx] = 1'b1;
      @(posedge clk); #1;
      start[idx] = 1'b0;
      while (cyc <= 400 && done_cyc == 0) begin
         n_upd  += int'(w_upd[idx]);
         n_z1   += int'(w_z1[idx]);
         n_term += int'(w_term[idx]);
         n_chk  += int'(chk[idx]);
         n_res  += int'(w_res[idx]);
         if ($countones({w_upd[idx], w_z1[idx], w_res[idx], w_term[idx]}) > 1) bad_onehot++;
         if (alu_mode[idx] != 3'd0 && !sel_a[idx]) bad_mode++;
         if (!busy[idx]) bad_busy++;
         if (done[idx]) begin
            done_cyc = cyc; got_err = err[idx]; got_iter = iter[idx];
         end
         start[idx] = busy_pulse && (cyc == 10 || cyc == 20);
         if (done_cyc == 0) begin
            @(posedge clk); #1;
            cyc++;
         end
      end
      start[idx] = 1'b0;
      if (exp_cyc == 1) begin
         e_upd = 0; e_z1 = 0; e_term = 0; e_chk = 0; e_res = 0;
      end else begin
         e_upd = 1; e_z1 = 1; e_term = int'(exp_iter) + 1; e_chk = e_term; e_res = int'(exp_iter);
      end
      n_cmp++; if (done_cyc !== exp_cyc) begin n_fail++; $display("FAIL %s done_cycle: got %0d need %0d", name, done_cyc, exp_cyc); end
      n_cmp++; if (got_err !== exp_err) begin n_fail++; $display("FAIL %s error_o: got %b need %b", name, got_err, exp_err); end
      n_cmp++; if (got_iter !== exp_iter) begin n_fail++; $display("FAIL %s iter_o: got %0d need %0d", name, got_iter, exp_iter); end
      n_cmp++; if (erg[idx] !== exp_erg) begin n_fail++; $display("FAIL %s ergebnis: got %0d need %0d", name, erg[idx], exp_erg); end
      n_cmp++;
      if ({n_upd, n_z1, n_term, n_chk, n_res} !== {e_upd, e_z1, e_term, e_chk, e_res}) begin
         n_fail++;
         $display("FAIL %s strobe_counts upd/z1/term/chk/res: got %0d/%0d/%0d/%0d/%0d need %0d/%0d/%0d/%0d/%0d",
                  name, n_upd, n_z1, n_term, n_chk, n_res, e_upd, e_z1, e_term, e_chk, e_res);
      end
      n_cmp++;
      if ({bad_onehot, bad_mode, bad_busy} !== {32'd0, 32'd0, 32'd0}) begin
         n_fail++;
         $display("FAIL %s strobe_rules onehot/mode/busy violations: got %0d/%0d/%0d need 0/0/0",
                  name, bad_onehot, bad_mode, bad_busy);
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({busy[idx], done[idx], iter[idx]} !== {2'b00, exp_iter}) begin
         n_fail++;
         $display("FAIL %s idle_after: got busy=%b done=%b iter=%0d need 0 0 %0d",
                  name, busy[idx], done[idx], iter[idx], exp_iter);
      end
   endtask

   task automatic test_basic();
      run_op(0, 16'd17, 16'd5, 28, 1'b0, 16'd3, 16'd2, 1'b0, "17mod5");
      run_op(0, 16'd3,  16'd7,  7, 1'b0, 16'd0, 16'd3, 1'b0, "3mod7");
   endtask

   task automatic test_equality();
      run_op(0, 16'd12, 16'd4, 28, 1'b0, 16'd3, 16'd0, 1'b0, "12mod4");
   endtask

   // Illegal operands: iter_o and the datapath result keep the 12 mod 4 values.
   task automatic test_illegal();
      run_op(0, 16'd9,     16'd0,     1, 1'b1, 16'd3, 16'd0, 1'b0, "div_zero");
      run_op(0, 16'h8000,  16'd3,     1, 1'b1, 16'd3, 16'd0, 1'b0, "neg_dividend");
      run_op(0, 16'd9,     16'hFFFD,  1, 1'b1, 16'd3, 16'd0, 1'b0, "neg_divisor");
   endtask

   task automatic test_watchdog();
      run_op(1, 16'd100, 16'd3, 35, 1'b1, 16'd4, 16'd88, 1'b1, "watchdog");
   endtask

   task automatic test_reset_abort();
      int saw_done = 0;
      z1[0] = 16'd17; z2[0] = 16'd5; start[0] = 1'b1;
      @(posedge clk); #1;
      start[0] = 1'b0;
      repeat (7) begin @(posedge clk); #1; end
      n_cmp++;
      if (w_res[0] !== 1'b0 || alu_mode[0] !== 3'd1) begin
         n_fail++; $display("FAIL abort_in_sub: got mode=%0d need 1 (SUB, not last cycle)", alu_mode[0]);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_cmp++;
      if ({alu_mode[0], w_upd[0], w_z1[0], w_res[0], w_term[0], sel_a[0], sel_b[0], chk[0],
           busy[0], done[0], err[0], iter[0]} !== 29'd0) begin
         n_fail++;
         $display("FAIL abort_outputs: got mode=%0d busy=%b done=%b iter=%0d, need all 0",
                  alu_mode[0], busy[0], done[0], iter[0]);
      end
      repeat (30) begin
         if (done[0]) saw_done++;
         @(posedge clk); #1;
      end
      n_cmp++;
      if (saw_done !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses need 0", saw_done); end
      run_op(0, 16'd9, 16'd4, 21, 1'b0, 16'd2, 16'd1, 1'b0, "9mod4_after_abort");
   endtask

   initial begin
      start = '0; z1 = '0; z2 = '0;
      test_reset();
      test_basic();
      test_equality();
      test_illegal();
      test_watchdog();
      test_reset_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
